// File: rtl/shift_unit_mc_if.sv
// Request/response bundle between the issue logic and the multi-cycle shifter.
// The master is the issue side; the slave is the shift unit.
interface shift_unit_mc_if;
  logic        in_valid;
  logic        in_ready;
  logic        sr;
  logic        arith;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;
  logic        flush;

  modport master (
    output in_valid,
    output sr,
    output arith,
    output shamt,
    output data_in,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  sr,
    input  arith,
    input  shamt,
    input  data_in,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output data_out,
    output busy
  );
endinterface

// File: rtl/shift_unit_mc.sv
// Multi-cycle SLL/SRL/SRA unit: shifts STEP bit positions per clock until the
// requested amount is consumed, then holds the result until it is taken.
module shift_unit_mc #(
  parameter int unsigned STEP = 1  // 1, 2, 4, 8 or 16
) (
  input logic           clk,
  input logic           rst,
  shift_unit_mc_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [4:0] StepAmt = 5'(STEP);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic        op_sr_q, op_sr_d;
  logic        op_arith_q, op_arith_d;

  logic [4:0]         step_k;
  logic               fill;
  logic signed [32:0] right_ext;
  logic [31:0]        shifted;

  // Per-cycle shift datapath: k = min(STEP, rem), fill taken from the live sign bit.
  always_comb begin
    step_k    = (rem_q < StepAmt) ? rem_q : StepAmt;
    fill      = op_arith_q & acc_q[31];
    // Extending by the fill bit lets one arithmetic shift serve both SRL and SRA.
    right_ext = $signed({fill, acc_q}) >>> step_k;
    if (op_sr_q) begin
      shifted = right_ext[31:0];
    end else begin
      shifted = acc_q << step_k;
    end
  end

  // Next-state and operand capture; flush overrides everything else.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    op_sr_d    = op_sr_q;
    op_arith_d = op_arith_q;

    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            acc_d      = bus.data_in;
            rem_d      = bus.shamt;
            op_sr_d    = bus.sr;
            op_arith_d = bus.arith & bus.sr;
            state_d    = (bus.shamt == 5'd0) ? StDone : StShift;
          end
        end
        StShift: begin
          acc_d = shifted;
          rem_d = rem_q - step_k;
          if (rem_q == step_k) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= 32'd0;
      rem_q      <= 5'd0;
      op_sr_q    <= 1'b0;
      op_arith_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      op_sr_q    <= op_sr_d;
      op_arith_q <= op_arith_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.data_out  = acc_q;

endmodule

// File: tb/tb_shift_unit_mc.sv
// Drives one request stream into five shifters (STEP = 1, 2, 4, 8, 16) and checks
// each result and latency against plain shift operators and ceil(shamt/STEP).
module tb_shift_unit_mc;

  localparam int NDut = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sr;
  logic        arith;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        out_ready;
  logic        flush;

  logic        in_ready_v  [NDut];
  logic        out_valid_v [NDut];
  logic        busy_v      [NDut];
  logic [31:0] data_out_v  [NDut];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    shift_unit_mc_if bus ();

    assign bus.in_valid  = in_valid;
    assign bus.sr        = sr;
    assign bus.arith     = arith;
    assign bus.shamt     = shamt;
    assign bus.data_in   = data_in;
    assign bus.out_ready = out_ready;
    assign bus.flush     = flush;

    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign busy_v[g]      = bus.busy;
    assign data_out_v[g]  = bus.data_out;

    shift_unit_mc #(
      .STEP (1 << g)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic logic [31:0] ref_shift(input logic s, input logic a, input logic [4:0] n,
                                            input logic [31:0] d);
    if (!s) return d << n;
    if (a) return $signed(d) >>> n;
    return d >> n;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, 1 << idx, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {in_ready, out_valid, busy} for one unit
  function automatic logic [31:0] flags(input int i);
    return {29'd0, in_ready_v[i], out_valid_v[i], busy_v[i]};
  endfunction

  task automatic run_op(input logic s, input logic a, input logic [4:0] n, input logic [31:0] d,
                        input int hold);
    int          lat [NDut];
    logic [31:0] exp;
    bit          all_done;
    sr       = s;
    arith    = a;
    shamt    = n;
    data_in  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble the request inputs; the units must ignore them while busy.
    sr       = 1'($urandom);
    arith    = 1'($urandom);
    shamt    = 5'($urandom);
    data_in  = $urandom;
    exp      = ref_shift(s, a, n, d);
    for (int i = 0; i < NDut; i++) lat[i] = -1;
    for (int c = 0; c <= 40; c++) begin
      all_done = 1'b1;
      for (int i = 0; i < NDut; i++) begin
        if (lat[i] < 0) begin
          if (out_valid_v[i]) begin
            lat[i] = c;
          end else begin
            chk("busy_while_shifting", i, flags(i), 32'b001);
            all_done = 1'b0;
          end
        end
      end
      if (all_done) break;
      tick();
    end
    for (int i = 0; i < NDut; i++) begin
      chk("latency", i, 32'(lat[i]), 32'((int'(n) + (1 << i) - 1) / (1 << i)));
      chk("data_out", i, data_out_v[i], exp);
    end
    repeat (hold) begin
      tick();
      for (int i = 0; i < NDut; i++) begin
        chk("stall_data", i, data_out_v[i], exp);
        chk("stall_flags", i, flags(i), 32'b011);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < NDut; i++) chk("release_idle", i, flags(i), 32'b100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    in_valid  = 1'b0;
    sr        = 1'b0;
    arith     = 1'b0;
    shamt     = 5'd0;
    data_in   = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #12;
    for (int i = 0; i < NDut; i++) begin
      chk("reset_flags", i, flags(i), 32'b100);
      chk("reset_data", i, data_out_v[i], 32'd0);
    end
    rst = 1'b0;
    tick();

    // Directed cases
    run_op(1'b0, 1'b0, 5'd31, 32'h0000_0001, 0);
    run_op(1'b1, 1'b1, 5'd4, 32'h8000_0000, 0);
    run_op(1'b1, 1'b0, 5'd4, 32'h8000_0000, 0);
    run_op(1'b1, 1'b1, 5'd31, 32'hF000_00F0, 0);
    run_op(1'b1, 1'b1, 5'd9, 32'hF000_00F0, 0);
    run_op(1'b0, 1'b1, 5'd0, 32'h1234_5678, 0);
    run_op(1'b1, 1'b1, 5'd0, 32'h1234_5678, 0);
    run_op(1'b0, 1'b1, 5'd5, 32'h8765_4321, 0);
    run_op(1'b1, 1'b0, 5'd7, 32'hA5A5_5A5A, 10);
    run_op(1'b1, 1'b1, 5'd16, 32'h8000_0001, 0);

    // Flush mid-shift: back to idle, no result ever appears
    sr       = 1'b0;
    arith    = 1'b0;
    shamt    = 5'd31;
    data_in  = 32'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < NDut; i++) chk("flush_idle", i, flags(i), 32'b100);
    seen = 1'b0;
    repeat (40) begin
      tick();
      for (int i = 0; i < NDut; i++) seen |= out_valid_v[i] | ~in_ready_v[i];
    end
    chk("flush_quiet", 0, {31'd0, seen}, 32'd0);

    // Flush wins over a simultaneous request
    shamt    = 5'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < NDut; i++) chk("flush_blocks_accept", i, flags(i), 32'b100);
    run_op(1'b1, 1'b1, 5'd3, 32'hFFFF_0000, 0);

    // Asynchronous reset in the middle of a shift
    sr       = 1'b1;
    arith    = 1'b1;
    shamt    = 5'd31;
    data_in  = 32'h8000_1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("async_reset_flags", i, flags(i), 32'b100);
      chk("async_reset_data", i, data_out_v[i], 32'd0);
    end
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i < NDut; i++) chk("post_reset_idle", i, flags(i), 32'b100);

    // Randomized operations
    for (int t = 0; t < 2000; t++) begin
      run_op(1'($urandom), 1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_unit_mc.md
Name: shift_unit_mc

Overview:
Multi-cycle, low-area shift unit for the ALU. It supports SLL, SRL and SRA and shifts STEP bit positions per clock. The ALU/issue logic sends a request to it over a valid/ready handshake and takes the result back over a second handshake. It is the sequential counterpart to the single-cycle shifter, for area-constrained builds where the issue stage can stall on long shifts.

Parameters:
STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  request present
in_ready  output  1  unit can accept a request (high only in IDLE)
sr  input  1  1 = shift right, 0 = shift left
arith  input  1  1 = arithmetic right shift; ignored when sr=0
shamt  input  5  shift amount 0..31
data_in  input  32  operand
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  consumer accepts the result
data_out  output  32  result; stable while out_valid=1
busy  output  1  state != IDLE
flush  input  1  synchronous abort of the in-flight operation

Behaviour:
- States: IDLE, SHIFT, DONE.
- Internal registers: op_sr, op_arith, rem[4:0] (shift amount remaining), acc[31:0] (working value). data_out = acc.
- Reset (async, rst=1): state=IDLE, acc=0, rem=0. Outputs: in_ready=1, out_valid=0, busy=0, data_out=0. Reset mid-operation discards the operation with no output.
- Combinational outputs: in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - When in_valid=1, the edge accepts the request: latch acc=data_in, rem=shamt, op_sr=sr, op_arith=arith&sr.
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT, on each edge:
  - k = min(STEP, rem).
  - Left shift: acc <<= k, zero fill.
  - Right shift: acc >>= k, filling with fill = op_arith ? acc[31] : 0.
  - rem -= k. Move to DONE when the new rem is 0.
- Latency: L = ceil(shamt/STEP) edges after the accepting edge until out_valid=1; L=0 when shamt=0, so out_valid is high in the cycle right after acceptance. Examples: STEP=1, shamt=31 gives L=31; STEP=8, shamt=31 gives L=4.
- DONE:
  - Hold acc.
  - When out_ready=1, go to IDLE at that edge.
  - Holding out_ready=0 stalls indefinitely with data_out stable.
- Throughput: no request is accepted in the same edge as a result is consumed, because in_ready=0 in DONE. The minimum spacing between accepts is L+2 cycles.
- flush:
  - flush=1 at an edge forces IDLE from any state. acc and rem hold their values (don't-care).
  - flush has priority over acceptance and over shifting: in IDLE with in_valid=1 and flush=1, nothing is accepted.
- Data width rules:
  - Fill is taken from the current acc[31] each step. This equals the original sign, since SRA preserves bit 31.
  - The result equals the single-cycle reference: SLL gives data_in<<shamt; SRL gives data_in>>shamt; SRA gives $signed(data_in)>>>shamt.
- Input changes while not in IDLE are ignored.

Test Plan:
- STEP=1, SLL, data_in=0x0000_0001, shamt=31 → out_valid after 31 edges, data_out=0x8000_0000; busy=1 throughout.
- STEP=1, SRA, data_in=0x8000_0000, shamt=4 → data_out=0xF800_0000 after 4 edges. Same input with SRL → 0x0800_0000.
- STEP=8, SRA, data_in=0xF000_00F0, shamt=31 → out_valid after 4 edges, data_out=0xFFFF_FFFF. Same input with shamt=9 → 2 edges, data_out=0xFFF8_0000.
- shamt=0, any op, data_in=0x1234_5678 → out_valid one cycle after accept, data_out=0x1234_5678. Setting sr=0 with arith=1 behaves as SLL.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE → data_out stable, in_ready=0. Release → IDLE, then accept the next request.
  - Assert flush in SHIFT → IDLE next cycle, out_valid never rises.
- Assert rst asynchronously mid-SHIFT → outputs go immediately to their reset values (data_out=0, in_ready=1). Randomized check of 10k ops against $signed/shift operators for STEP ∈ {1, 2, 4, 8, 16}.
